// File: rtl/bullet_pkg.sv
// Shared types and default constants for the bullet controller.
// Sprite geometry, flight step and re-arm delay live here.
package bullet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_t;

  localparam int SIZE            = 16;
  localparam int STEP            = 4;
  localparam int COOLDOWN_FRAMES = 8;

endpackage

// File: rtl/bullet_controller_if.sv
// Pixel/ROM bus between the VGA side and the bullet controller.
// The VGA side drives the draw position; the controller answers with ROM address and visibility.
interface bullet_controller_if;

  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [18:0] read_address;
  logic        bullet_on;

  modport master (
    output DrawX,
    output DrawY,
    input  read_address,
    input  bullet_on
  );

  modport slave (
    input  DrawX,
    input  DrawY,
    output read_address,
    output bullet_on
  );

endinterface

// File: rtl/frame_tick_det.sv
// Rising-edge detector on the vsync-derived frame level.
// Produces a one-Clk tick the cycle after a sampled 0->1 transition.
module frame_tick_det (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic cur;
  logic prev;

  // Two-deep history of the sampled frame level
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= frame_clk;
      prev <= cur;
    end
  end

  assign tick = cur & ~prev;

endmodule

// File: rtl/bullet_controller.sv
// Single-bullet controller: launch from ship, climb per frame, cooldown, re-arm.
// Also maps the current draw pixel into the bullet sprite ROM.
module bullet_controller #(
  parameter int SIZE            = bullet_pkg::SIZE,
  parameter int STEP            = bullet_pkg::STEP,
  parameter int COOLDOWN_FRAMES = bullet_pkg::COOLDOWN_FRAMES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              fire,
  input  logic              hit,
  input  logic [9:0]        ship_x,
  input  logic [9:0]        ship_y,
  output logic              active,
  output logic [9:0]        bullet_x,
  output logic [9:0]        bullet_y,
  bullet_controller_if.slave pix
);

  import bullet_pkg::*;

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [9:0] SZ = 10'(SIZE);
  localparam logic [9:0] ST = 10'(STEP);
  localparam logic [CW-1:0] CD = CW'(COOLDOWN_FRAMES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic          in_box;

  frame_tick_det u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Flight FSM; hit overrides a coincident tick while flying
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      active   <= 1'b0;
      bullet_x <= '0;
      bullet_y <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick && fire) begin
            state    <= FLYING;
            active   <= 1'b1;
            bullet_x <= ship_x;
            bullet_y <= (ship_y < SZ) ? 10'd0 : ship_y - SZ;
          end
        end
        FLYING: begin
          if (hit) begin
            state  <= COOLDOWN;
            active <= 1'b0;
            cnt    <= CD;
          end else if (tick) begin
            if (bullet_y < ST) begin
              state  <= COOLDOWN;
              active <= 1'b0;
              cnt    <= CD;
            end else begin
              bullet_y <= bullet_y - ST;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cnt <= CW'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  // Offsets wrap for pixels left of / above the bullet, failing the box test
  assign dx     = pix.DrawX - bullet_x;
  assign dy     = pix.DrawY - bullet_y;
  assign in_box = (dx < SZ) && (dy < SZ);

  assign pix.read_address = in_box
    ? ({9'd0, dy} * 19'(SIZE) + {9'd0, dx})
    : 19'd0;

  // Visibility delayed one cycle to line up with the registered ROM output
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix.bullet_on <= 1'b0;
    end else begin
      pix.bullet_on <= in_box & active;
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller.
// Frame ticks are produced by toggling frame_clk over several Clk cycles.
module tb_bullet_controller;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       fire;
  logic       hit;
  logic [9:0] ship_x;
  logic [9:0] ship_y;
  logic       active;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;

  int n_checks;
  int n_fail;

  bullet_controller_if pix ();

  bullet_controller dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .fire      (fire),
    .hit       (hit),
    .ship_x    (ship_x),
    .ship_y    (ship_y),
    .active    (active),
    .bullet_x  (bullet_x),
    .bullet_y  (bullet_y),
    .pix       (pix)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    frame_clk = 1'b0;
    fire = 1'b0;
    hit = 1'b0;
    ship_x = 10'd0;
    ship_y = 10'd0;
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_active got %0b want 0", active);
    end
    n_checks++;
    if (bullet_x !== 10'd0 || bullet_y !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_pos got (%0d,%0d) want (0,0)", bullet_x, bullet_y);
    end
    n_checks++;
    if (pix.bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_on got %0b want 0", pix.bullet_on);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    do_tick();
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_nofire got %0b want 0", active);
    end
  endtask

  task automatic test_fire();
    ship_x = 10'd100;
    ship_y = 10'd200;
    fire = 1'b1;
    do_tick();
    fire = 1'b0;
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL fire_active got %0b want 1", active);
    end
    n_checks++;
    if (bullet_x !== 10'd100 || bullet_y !== 10'd184) begin
      n_fail++;
      $display("FAIL fire_pos got (%0d,%0d) want (100,184)", bullet_x, bullet_y);
    end
  endtask

  task automatic test_address();
    @(negedge Clk);
    pix.DrawX = 10'd105;
    pix.DrawY = 10'd186;
    #1;
    n_checks++;
    if (pix.read_address !== 19'd37) begin
      n_fail++;
      $display("FAIL addr_in got %0d want 37", pix.read_address);
    end
    n_checks++;
    if (pix.bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL on_latency got %0b want 0", pix.bullet_on);
    end
    @(negedge Clk);
    n_checks++;
    if (pix.bullet_on !== 1'b1) begin
      n_fail++;
      $display("FAIL on_in got %0b want 1", pix.bullet_on);
    end
    pix.DrawX = 10'd99;
    #1;
    n_checks++;
    if (pix.read_address !== 19'd0) begin
      n_fail++;
      $display("FAIL addr_left got %0d want 0", pix.read_address);
    end
    @(negedge Clk);
    n_checks++;
    if (pix.bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL on_left got %0b want 0", pix.bullet_on);
    end
    pix.DrawX = 10'd115;
    pix.DrawY = 10'd199;
    #1;
    n_checks++;
    if (pix.read_address !== 19'd255) begin
      n_fail++;
      $display("FAIL addr_corner got %0d want 255", pix.read_address);
    end
    pix.DrawX = 10'd116;
    #1;
    n_checks++;
    if (pix.read_address !== 19'd0) begin
      n_fail++;
      $display("FAIL addr_right got %0d want 0", pix.read_address);
    end
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
  endtask

  task automatic test_step();
    fire = 1'b1;
    ship_x = 10'd300;
    do_tick();
    fire = 1'b0;
    n_checks++;
    if (bullet_y !== 10'd180 || bullet_x !== 10'd100) begin
      n_fail++;
      $display("FAIL step_pos got (%0d,%0d) want (100,180)", bullet_x, bullet_y);
    end
  endtask

  task automatic test_hit();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk);
    #1 hit = 1'b1;
    @(posedge Clk);
    #1 hit = 1'b0;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_active got %0b want 0", active);
    end
    n_checks++;
    if (bullet_y !== 10'd180) begin
      n_fail++;
      $display("FAIL hit_y got %0d want 180", bullet_y);
    end
    apply_reset();
  endtask

  task automatic test_top_exit();
    ship_x = 10'd40;
    ship_y = 10'd19;
    fire = 1'b1;
    do_tick();
    n_checks++;
    if (active !== 1'b1 || bullet_y !== 10'd3) begin
      n_fail++;
      $display("FAIL exit_launch got act=%0b y=%0d want act=1 y=3", active, bullet_y);
    end
    ship_y = 10'd50;
    do_tick();
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_cool got %0b want 0", active);
    end
    for (int i = 0; i < 8; i++) begin
      do_tick();
      n_checks++;
      if (active !== 1'b0) begin
        n_fail++;
        $display("FAIL cool_tick%0d got %0b want 0", i, active);
      end
    end
    do_tick();
    fire = 1'b0;
    n_checks++;
    if (active !== 1'b1 || bullet_y !== 10'd34 || bullet_x !== 10'd40) begin
      n_fail++;
      $display("FAIL rearm got act=%0b pos=(%0d,%0d) want act=1 pos=(40,34)",
               active, bullet_x, bullet_y);
    end
  endtask

  task automatic test_reset_mid_flight();
    pix.DrawX = 10'd41;
    pix.DrawY = 10'd35;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (pix.bullet_on !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_on got %0b want 1", pix.bullet_on);
    end
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if (active !== 1'b0 || pix.bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got act=%0b on=%0b want 0 0", active, pix.bullet_on);
    end
    n_checks++;
    if (bullet_y !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset_y got %0d want 0", bullet_y);
    end
    #1 Reset = 1'b0;
    do_tick();
    do_tick();
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL no_resume got %0b want 0", active);
    end
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
  endtask

  task automatic test_edge_clamp();
    ship_x = 10'd7;
    ship_y = 10'd10;
    fire = 1'b1;
    do_tick();
    fire = 1'b0;
    n_checks++;
    if (active !== 1'b1 || bullet_y !== 10'd0 || bullet_x !== 10'd7) begin
      n_fail++;
      $display("FAIL clamp got act=%0b pos=(%0d,%0d) want act=1 pos=(7,0)",
               active, bullet_x, bullet_y);
    end
    do_tick();
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_exit got %0b want 0", active);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fire();
    test_address();
    test_step();
    test_hit();
    test_top_exit();
    test_reset_mid_flight();
    test_edge_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
